// File: rtl/delay_sum_beamformer.sv
// Delay-and-sum beamformer: per-channel circular history, steerable integer delays,
// four-stage accept/read/sum/output pipeline producing the channel average.
module delay_sum_beamformer #(
  parameter int unsigned NUM_RECEIVERS = 4,
  parameter int unsigned SAMPLE_WIDTH  = 16,
  parameter int unsigned DEPTH         = 64,
  parameter int unsigned SIN_WIDTH     = 17,
  parameter int unsigned STEP_SAMPLES  = 26
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  input  logic [NUM_RECEIVERS*SAMPLE_WIDTH-1:0] adc_in,
  input  logic                                  data_valid_in,
  input  logic [SIN_WIDTH-1:0]                  sin_theta,
  input  logic                                  sign_bit,
  input  logic                                  angle_valid_in,
  output logic [SAMPLE_WIDTH-1:0]               aggregated_waveform,
  output logic                                  data_valid_out,
  output logic                                  primed_out,
  output logic                                  delay_clamped_out
);

  localparam int unsigned LogN  = $clog2(NUM_RECEIVERS);
  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = AddrW + 1;
  localparam int unsigned SumW  = SAMPLE_WIDTH + LogN;

  typedef enum logic [0:0] {StFill = 1'b0, StRun = 1'b1} state_e;

  state_e                    state_q, state_d;
  logic [CntW-1:0]           fill_q, fill_d;
  logic [AddrW-1:0]          wp_q, wp_d;
  logic                      clamp_q, clamp_d;
  logic [AddrW-1:0]          dly_q [NUM_RECEIVERS];
  logic [AddrW-1:0]          dly_d [NUM_RECEIVERS];
  logic [AddrW-1:0]          rd_addr_q [NUM_RECEIVERS];
  logic [AddrW-1:0]          rd_addr_d [NUM_RECEIVERS];
  logic signed [SAMPLE_WIDTH-1:0] rd_q [NUM_RECEIVERS];
  logic signed [SAMPLE_WIDTH-1:0] rd_d [NUM_RECEIVERS];
  logic                      v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic signed [SumW-1:0]    sum_q, sum_d, sum_tree;
  logic [SAMPLE_WIDTH-1:0]   agg_q, agg_d;
  logic                      dv_out_q, dv_out_d;

  logic signed [SAMPLE_WIDTH-1:0] mem_q [NUM_RECEIVERS][DEPTH];

  logic [31:0]               dly_raw [NUM_RECEIVERS];
  logic [AddrW-1:0]          new_dly [NUM_RECEIVERS];
  logic                      clamp_any;
  logic                      last_fill;

  // Steering delays from the sine input; saturate rather than wrap so a steep angle
  // never aliases onto a short delay.
  always_comb begin
    clamp_any = 1'b0;
    for (int i = 0; i < NUM_RECEIVERS; i++) begin
      dly_raw[i] = (32'(STEP_SAMPLES)
                    * (sign_bit ? 32'(NUM_RECEIVERS - 1 - i) : 32'(i))
                    * 32'(sin_theta)) >> (SIN_WIDTH - 1);
      if (dly_raw[i] > 32'(DEPTH - 1)) begin
        new_dly[i] = AddrW'(DEPTH - 1);
        clamp_any  = 1'b1;
      end else begin
        new_dly[i] = dly_raw[i][AddrW-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    wp_d      = wp_q;
    clamp_d   = clamp_q | (angle_valid_in & clamp_any);
    last_fill = (fill_q == CntW'(DEPTH - 1));
    if (data_valid_in) begin
      wp_d = wp_q + 1'b1;
    end
    if (state_q == StFill && data_valid_in) begin
      fill_d = fill_q + 1'b1;
      if (last_fill) begin
        state_d = StRun;
      end
    end
    // The 64th fill sample is the first one with a complete history behind it.
    v1_d     = data_valid_in & ((state_q == StRun) | last_fill);
    v2_d     = v1_q;
    v3_d     = v2_q;
    dv_out_d = v3_q;
    for (int i = 0; i < NUM_RECEIVERS; i++) begin
      dly_d[i]     = angle_valid_in ? new_dly[i] : dly_q[i];
      rd_addr_d[i] = wp_q - dly_q[i];
      rd_d[i]      = v1_q ? mem_q[i][rd_addr_q[i]] : rd_q[i];
    end
    sum_tree = '0;
    for (int i = 0; i < NUM_RECEIVERS; i++) begin
      sum_tree = sum_tree + {{LogN{rd_q[i][SAMPLE_WIDTH-1]}}, rd_q[i]};
    end
    sum_d = v2_q ? sum_tree : sum_q;
    agg_d = v3_q ? SAMPLE_WIDTH'(sum_q >>> LogN) : agg_q;
  end

  always_ff @(posedge clk_in) begin
    if (data_valid_in) begin
      for (int i = 0; i < NUM_RECEIVERS; i++) begin
        mem_q[i][wp_q] <= adc_in[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= StFill;
      fill_q   <= '0;
      wp_q     <= '0;
      clamp_q  <= 1'b0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      sum_q    <= '0;
      agg_q    <= '0;
      dv_out_q <= 1'b0;
      for (int i = 0; i < NUM_RECEIVERS; i++) begin
        dly_q[i]     <= '0;
        rd_addr_q[i] <= '0;
        rd_q[i]      <= '0;
      end
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      wp_q     <= wp_d;
      clamp_q  <= clamp_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      sum_q    <= sum_d;
      agg_q    <= agg_d;
      dv_out_q <= dv_out_d;
      for (int i = 0; i < NUM_RECEIVERS; i++) begin
        dly_q[i]     <= dly_d[i];
        rd_addr_q[i] <= rd_addr_d[i];
        rd_q[i]      <= rd_d[i];
      end
    end
  end

  assign aggregated_waveform = agg_q;
  assign data_valid_out      = dv_out_q;
  assign primed_out          = (state_q == StRun);
  assign delay_clamped_out   = clamp_q;

endmodule

// File: tb/tb_delay_sum_beamformer.sv
// Bench for delay_sum_beamformer: directed scenarios plus a random stream, all checked
// against a sample-history model of the delay-and-average function.
module tb_delay_sum_beamformer;

  localparam int NR    = 4;
  localparam int SW    = 16;
  localparam int DEPTH = 64;
  localparam int SINW  = 17;
  localparam int STEP  = 26;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic [NR*SW-1:0]  adc_in;
  logic              data_valid_in;
  logic [SINW-1:0]   sin_theta;
  logic              sign_bit;
  logic              angle_valid_in;
  logic [SW-1:0]     aggregated_waveform;
  logic              data_valid_out;
  logic              primed_out;
  logic              delay_clamped_out;

  always #5 clk_in = ~clk_in;

  delay_sum_beamformer dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .adc_in              (adc_in),
    .data_valid_in       (data_valid_in),
    .sin_theta           (sin_theta),
    .sign_bit            (sign_bit),
    .angle_valid_in      (angle_valid_in),
    .aggregated_waveform (aggregated_waveform),
    .data_valid_out      (data_valid_out),
    .primed_out          (primed_out),
    .delay_clamped_out   (delay_clamped_out)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model state: full sample history since reset, current delays, expected outputs.
  int smp [NR];
  int hist [NR][$];
  int mdly [NR];
  bit mcl;
  int mcnt;
  int due_q [$];
  int val_q [$];
  bit exp_dv;
  int exp_agg;

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      hist[i].delete();
      mdly[i] = 0;
    end
    mcl     = 1'b0;
    mcnt    = 0;
    due_q.delete();
    val_q.delete();
    exp_dv  = 1'b0;
    exp_agg = 0;
  endtask

  task automatic step(input bit dv, input bit av, input int sn, input bit sg);
    int     s, n, q, k;
    longint p;
    for (int i = 0; i < NR; i++) adc_in[i*SW +: SW] = SW'(smp[i]);
    data_valid_in  = dv;
    angle_valid_in = av;
    sin_theta      = SINW'(sn);
    sign_bit       = sg;
    @(posedge clk_in);
    #1;
    cyc++;
    if (dv) begin
      for (int i = 0; i < NR; i++) hist[i].push_back(smp[i]);
      mcnt++;
      if (mcnt >= DEPTH) begin
        n = hist[0].size() - 1;
        s = 0;
        for (int i = 0; i < NR; i++) s += hist[i][n - mdly[i]];
        q = s / NR;
        if (s < 0 && (s % NR) != 0) q--;
        due_q.push_back(cyc + 3);
        val_q.push_back(q);
      end
    end
    if (av) begin
      for (int i = 0; i < NR; i++) begin
        k = sg ? (NR - 1 - i) : i;
        p = longint'(STEP) * k * sn / 65536;
        if (p > DEPTH - 1) begin
          p   = DEPTH - 1;
          mcl = 1'b1;
        end
        mdly[i] = int'(p);
      end
    end
    exp_dv = 1'b0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      exp_dv  = 1'b1;
      exp_agg = val_q.pop_front();
      void'(due_q.pop_front());
    end
    data_valid_in  = 1'b0;
    angle_valid_in = 1'b0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    #1;
    rst_in = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({aggregated_waveform, data_valid_out, primed_out, delay_clamped_out} !== '0) begin
      errors++;
      $display("FAIL reset_async got agg=%0d dv=%b pr=%b cl=%b want all 0",
               $signed(aggregated_waveform), data_valid_out, primed_out, delay_clamped_out);
    end
    @(posedge clk_in);
    #1;
    checks++;
    if ({aggregated_waveform, data_valid_out, primed_out, delay_clamped_out} !== '0) begin
      errors++;
      $display("FAIL reset_held got agg=%0d dv=%b pr=%b cl=%b want all 0",
               $signed(aggregated_waveform), data_valid_out, primed_out, delay_clamped_out);
    end
    rst_in = 1'b0;
    model_reset();
  endtask

  task automatic test_fill();
    do_reset();
    for (int n = 0; n <= 66; n++) begin
      for (int i = 0; i < NR; i++) smp[i] = n;
      step(n < 64, 1'b0, 0, 1'b0);
      checks++;
      if (data_valid_out !== exp_dv || aggregated_waveform !== SW'(exp_agg) ||
          primed_out !== (mcnt >= DEPTH) || delay_clamped_out !== mcl) begin
        errors++;
        $display("FAIL fill_stream cyc=%0d got dv=%b agg=%0d pr=%b cl=%b want dv=%b agg=%0d",
                 cyc, data_valid_out, $signed(aggregated_waveform), primed_out,
                 delay_clamped_out, exp_dv, exp_agg);
      end
      if (n == 62 || n == 63) begin
        checks++;
        if (primed_out !== 1'(n == 63)) begin
          errors++;
          $display("FAIL fill_primed n=%0d got %b want %b", n, primed_out, n == 63);
        end
      end
      if (n == 66) begin
        checks++;
        if (data_valid_out !== 1'b1 || aggregated_waveform !== 16'd63) begin
          errors++;
          $display("FAIL fill_first got dv=%b agg=%0d want dv=1 agg=63",
                   data_valid_out, $signed(aggregated_waveform));
        end
      end
    end
  endtask

  task automatic test_ramp();
    do_reset();
    step(1'b0, 1'b1, 32768, 1'b0);
    for (int n = 0; n <= 103; n++) begin
      for (int i = 0; i < NR; i++) smp[i] = n;
      step(1'b1, 1'b0, 0, 1'b0);
      checks++;
      if (data_valid_out !== exp_dv || aggregated_waveform !== SW'(exp_agg) ||
          primed_out !== (mcnt >= DEPTH) || delay_clamped_out !== mcl) begin
        errors++;
        $display("FAIL ramp_stream cyc=%0d got dv=%b agg=%0d want dv=%b agg=%0d",
                 cyc, data_valid_out, $signed(aggregated_waveform), exp_dv, exp_agg);
      end
      if (n == 103) begin
        checks++;
        if (data_valid_out !== 1'b1 || aggregated_waveform !== 16'd80) begin
          errors++;
          $display("FAIL ramp_n100 got dv=%b agg=%0d want dv=1 agg=80",
                   data_valid_out, $signed(aggregated_waveform));
        end
      end
    end
  endtask

  task automatic test_impulse();
    do_reset();
    step(1'b0, 1'b1, 32768, 1'b1);
    for (int n = 0; n <= 99; n++) begin
      for (int i = 0; i < NR; i++) smp[i] = 0;
      if (n == 50) smp[0] = 4000;
      step(1'b1, 1'b0, 0, 1'b0);
      checks++;
      if (data_valid_out !== exp_dv || aggregated_waveform !== SW'(exp_agg) ||
          primed_out !== (mcnt >= DEPTH)) begin
        errors++;
        $display("FAIL impulse_stream cyc=%0d got dv=%b agg=%0d want dv=%b agg=%0d",
                 cyc, data_valid_out, $signed(aggregated_waveform), exp_dv, exp_agg);
      end
      if (n == 92) begin
        checks++;
        if (data_valid_out !== 1'b1 || aggregated_waveform !== 16'd1000) begin
          errors++;
          $display("FAIL impulse_n89 got dv=%b agg=%0d want dv=1 agg=1000",
                   data_valid_out, $signed(aggregated_waveform));
        end
      end
    end
  endtask

  task automatic test_clamp();
    step(1'b0, 1'b1, 65536, 1'b0);
    checks++;
    if (delay_clamped_out !== 1'b1) begin
      errors++;
      $display("FAIL clamp_set got %b want 1", delay_clamped_out);
    end
    // Ramp x[n]=n with d=0,26,52,63 gives floor((4n-141)/4) = n-36.
    for (int n = 0; n <= 69; n++) begin
      for (int i = 0; i < NR; i++) smp[i] = n;
      step(1'b1, 1'b0, 0, 1'b0);
      checks++;
      if (data_valid_out !== exp_dv || aggregated_waveform !== SW'(exp_agg) ||
          delay_clamped_out !== mcl) begin
        errors++;
        $display("FAIL clamp_stream cyc=%0d got dv=%b agg=%0d cl=%b want dv=%b agg=%0d cl=%b",
                 cyc, data_valid_out, $signed(aggregated_waveform), delay_clamped_out,
                 exp_dv, exp_agg, mcl);
      end
      if (n == 69) begin
        checks++;
        if (aggregated_waveform !== 16'd30) begin
          errors++;
          $display("FAIL clamp_delays got agg=%0d want 30", $signed(aggregated_waveform));
        end
      end
    end
    step(1'b0, 1'b1, 0, 1'b0);
    checks++;
    if (delay_clamped_out !== 1'b1) begin
      errors++;
      $display("FAIL clamp_sticky got %b want 1", delay_clamped_out);
    end
  endtask

  task automatic test_extremes();
    do_reset();
    for (int n = 0; n <= 66; n++) begin
      for (int i = 0; i < NR; i++) smp[i] = -32768;
      step(n < 64, 1'b0, 0, 1'b0);
      checks++;
      if (data_valid_out !== exp_dv || aggregated_waveform !== SW'(exp_agg)) begin
        errors++;
        $display("FAIL neg_stream cyc=%0d got dv=%b agg=%0d want dv=%b agg=%0d",
                 cyc, data_valid_out, $signed(aggregated_waveform), exp_dv, exp_agg);
      end
    end
    checks++;
    if (aggregated_waveform !== 16'h8000) begin
      errors++;
      $display("FAIL neg_full got agg=%0d want -32768", $signed(aggregated_waveform));
    end
    for (int n = 0; n <= 3; n++) begin
      for (int i = 0; i < NR; i++) smp[i] = 32767;
      step(1'b1, 1'b0, 0, 1'b0);
    end
    checks++;
    if (data_valid_out !== 1'b1 || aggregated_waveform !== 16'h7fff) begin
      errors++;
      $display("FAIL pos_full got dv=%b agg=%0d want dv=1 agg=32767",
               data_valid_out, $signed(aggregated_waveform));
    end
    step(1'b0, 1'b1, 32768, 1'b0);
    // Sample 71 arrives with a load of sin=0 and must still see d=0,13,26,39.
    for (int n = 0; n <= 75; n++) begin
      for (int i = 0; i < NR; i++) smp[i] = n;
      step(1'b1, n == 71, 0, 1'b0);
      checks++;
      if (data_valid_out !== exp_dv || aggregated_waveform !== SW'(exp_agg)) begin
        errors++;
        $display("FAIL coincident_stream cyc=%0d got dv=%b agg=%0d want dv=%b agg=%0d",
                 cyc, data_valid_out, $signed(aggregated_waveform), exp_dv, exp_agg);
      end
      if (n == 74 || n == 75) begin
        checks++;
        if (aggregated_waveform !== ((n == 74) ? 16'd51 : 16'd72)) begin
          errors++;
          $display("FAIL coincident_old n=%0d got agg=%0d want %0d",
                   n, $signed(aggregated_waveform), (n == 74) ? 51 : 72);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b1, 65536, 1'b0);
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < NR; i++) smp[i] = 100 + n;
      step(1'b1, 1'b0, 0, 1'b0);
    end
    rst_in = 1'b1;
    #1;
    checks++;
    if ({aggregated_waveform, data_valid_out, primed_out, delay_clamped_out} !== '0) begin
      errors++;
      $display("FAIL midreset_async got agg=%0d dv=%b pr=%b cl=%b want all 0",
               $signed(aggregated_waveform), data_valid_out, primed_out, delay_clamped_out);
    end
    #1;
    rst_in = 1'b0;
    model_reset();
    for (int n = 0; n < 5; n++) begin
      step(1'b0, 1'b0, 0, 1'b0);
      checks++;
      if (data_valid_out !== 1'b0 || primed_out !== 1'b0) begin
        errors++;
        $display("FAIL midreset_flush got dv=%b pr=%b want dv=0 pr=0",
                 data_valid_out, primed_out);
      end
    end
    for (int n = 0; n <= 66; n++) begin
      for (int i = 0; i < NR; i++) smp[i] = int'($urandom_range(0, 65535)) - 32768;
      step(n < 64, 1'b0, 0, 1'b0);
      checks++;
      if (data_valid_out !== exp_dv || aggregated_waveform !== SW'(exp_agg) ||
          primed_out !== (mcnt >= DEPTH) || delay_clamped_out !== mcl) begin
        errors++;
        $display("FAIL refill_stream cyc=%0d got dv=%b agg=%0d pr=%b want dv=%b agg=%0d pr=%b",
                 cyc, data_valid_out, $signed(aggregated_waveform), primed_out,
                 exp_dv, exp_agg, mcnt >= DEPTH);
      end
    end
  endtask

  task automatic test_random();
    bit dv, av, sg;
    int sn;
    for (int c = 0; c < 800; c++) begin
      dv = ($urandom_range(0, 9) < 7);
      av = ($urandom_range(0, 24) == 0);
      sn = int'($urandom_range(0, 65536));
      sg = 1'($urandom_range(0, 1));
      for (int i = 0; i < NR; i++) smp[i] = int'($urandom_range(0, 65535)) - 32768;
      step(dv, av, sn, sg);
      checks++;
      if (data_valid_out !== exp_dv || aggregated_waveform !== SW'(exp_agg) ||
          primed_out !== (mcnt >= DEPTH) || delay_clamped_out !== mcl) begin
        errors++;
        $display("FAIL random_stream cyc=%0d got dv=%b agg=%0d pr=%b cl=%b want dv=%b agg=%0d",
                 cyc, data_valid_out, $signed(aggregated_waveform), primed_out,
                 delay_clamped_out, exp_dv, exp_agg);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    data_valid_in  = 1'b0;
    angle_valid_in = 1'b0;
    sin_theta      = '0;
    sign_bit       = 1'b0;
    adc_in         = '0;
    model_reset();
    test_reset();
    test_fill();
    test_ramp();
    test_impulse();
    test_clamp();
    test_extremes();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
